// File: rtl/vaddr_adder_pipe.sv
// Load/store virtual-address adder with handshaked operand stage and result FIFO.
// Optional SV57 canonical check: define VADDR_ADDER_SV57_EN.
package vaddr_adder_pkg;
  localparam int SATP_MODE_LEN = 4;
  localparam int LDST_TYPE_LEN = 3;

  localparam logic [SATP_MODE_LEN-1:0] SATP_MODE_BARE = 4'd0;
  localparam logic [SATP_MODE_LEN-1:0] SATP_MODE_SV39 = 4'd8;
  localparam logic [SATP_MODE_LEN-1:0] SATP_MODE_SV48 = 4'd9;
  localparam logic [SATP_MODE_LEN-1:0] SATP_MODE_SV57 = 4'd10;

  localparam logic [LDST_TYPE_LEN-1:0] LS_BYTE        = 3'd0;
  localparam logic [LDST_TYPE_LEN-1:0] LS_BYTE_U      = 3'd1;
  localparam logic [LDST_TYPE_LEN-1:0] LS_HALFWORD    = 3'd2;
  localparam logic [LDST_TYPE_LEN-1:0] LS_HALFWORD_U  = 3'd3;
  localparam logic [LDST_TYPE_LEN-1:0] LS_WORD        = 3'd4;
  localparam logic [LDST_TYPE_LEN-1:0] LS_WORD_U      = 3'd5;
  localparam logic [LDST_TYPE_LEN-1:0] LS_DOUBLEWORD  = 3'd6;

  typedef enum logic [1:0] {
    VADDER_NO_EXCEPT    = 2'd0,
    VADDER_ALIGN_EXCEPT = 2'd1,
    VADDER_PAGE_EXCEPT  = 2'd2
  } except_code_t;
endpackage

module vaddr_adder_pipe
  import vaddr_adder_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int IDX_LEN = 8,
  parameter int DEPTH   = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic [SATP_MODE_LEN-1:0]   vm_mode_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic                       is_store_i,
  input  logic [XLEN-1:0]            rs1_value_i,
  input  logic [XLEN-1:0]            imm_value_i,
  input  logic [IDX_LEN-1:0]         lsb_idx_i,
  input  logic [LDST_TYPE_LEN-1:0]   ldst_type_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic                       is_store_o,
  output logic [XLEN-1:0]            vaddr_o,
  output logic [IDX_LEN-1:0]         lsb_idx_o,
  output except_code_t               except_o,
  output logic [$clog2(DEPTH):0]     occupancy_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic                     is_store;
    logic [XLEN-1:0]          rs1;
    logic [XLEN-1:0]          imm;
    logic [IDX_LEN-1:0]       idx;
    logic [LDST_TYPE_LEN-1:0] ldst;
    logic [SATP_MODE_LEN-1:0] mode;
  } req_t;

  typedef struct packed {
    logic               is_store;
    logic [XLEN-1:0]    vaddr;
    logic [IDX_LEN-1:0] idx;
    except_code_t       exc;
  } rsp_t;

  logic           a_valid_q, a_valid_d;
  req_t           a_q;
  rsp_t           fifo_q [DEPTH];
  logic [PW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;

  logic [XLEN-1:0] sum;
  logic            align_err, page_err;
  rsp_t            rsp_d;
  logic            push, pop, accept;

  // Address and checks are evaluated on the registered operands.
  assign sum = a_q.rs1 + a_q.imm;

  always_comb begin
    align_err = 1'b0;
    case (a_q.ldst)
      LS_HALFWORD, LS_HALFWORD_U: align_err = sum[0];
      LS_WORD, LS_WORD_U:         align_err = |sum[1:0];
      LS_DOUBLEWORD:              align_err = |sum[2:0];
      default:                    align_err = 1'b0;
    endcase
  end

  always_comb begin
    page_err = 1'b0;
    case (a_q.mode)
      SATP_MODE_SV39: page_err = sum[XLEN-1:39] != {25{sum[38]}};
      SATP_MODE_SV48: page_err = sum[XLEN-1:48] != {16{sum[47]}};
`ifdef VADDR_ADDER_SV57_EN
      SATP_MODE_SV57: page_err = sum[XLEN-1:57] != {7{sum[56]}};
`endif
      default:        page_err = 1'b0;
    endcase
  end

  always_comb begin
    rsp_d.is_store = a_q.is_store;
    rsp_d.vaddr    = sum;
    rsp_d.idx      = a_q.idx;
    if (align_err)     rsp_d.exc = VADDER_ALIGN_EXCEPT;
    else if (page_err) rsp_d.exc = VADDER_PAGE_EXCEPT;
    else               rsp_d.exc = VADDER_NO_EXCEPT;
  end

  assign valid_o = count_q != '0;
  assign pop     = valid_o && ready_i;
  assign push    = a_valid_q && ((count_q < DEPTH_C) || pop);
  assign ready_o = !a_valid_q || push;
  assign accept  = valid_i && ready_o;

  always_comb begin
    a_valid_d = a_valid_q;
    if (accept)    a_valid_d = 1'b1;
    else if (push) a_valid_d = 1'b0;
    head_d  = pop  ? head_q + 1'b1 : head_q;
    tail_d  = push ? tail_q + 1'b1 : tail_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Flush shares the reset path and overrides any handshake in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      a_valid_q <= 1'b0;
      a_q       <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '{is_store: 1'b0, vaddr: '0, idx: '0, exc: VADDER_NO_EXCEPT};
      end
    end else begin
      a_valid_q <= a_valid_d;
      if (accept) begin
        a_q <= '{is_store: is_store_i, rs1: rs1_value_i, imm: imm_value_i,
                 idx: lsb_idx_i, ldst: ldst_type_i, mode: vm_mode_i};
      end
      if (push) fifo_q[tail_q] <= rsp_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign is_store_o  = fifo_q[head_q].is_store;
  assign vaddr_o     = fifo_q[head_q].vaddr;
  assign lsb_idx_o   = fifo_q[head_q].idx;
  assign except_o    = fifo_q[head_q].exc;
  assign occupancy_o = count_q + {{PW{1'b0}}, a_valid_q};

endmodule
